wb_write_queue: RTL and testbench

Buffers completed results from the ALU and load paths and drains them in order into the register file's single write port (write address, write enable, write data), at one write per cycle. It also answers busy queries for the two decode read addresses so that issue can stall on in-flight writes. A compile-time option adds youngest-match data forwarding. It sits between the execute/memory stages and the register file.

---
 rtl/wb_write_queue.sv | 126 ++++++++++++
 tb/tb_wb_write_queue.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/wb_write_queue.sv
// In-order writeback queue feeding the single register-file write port; optional forwarding under WB_QUEUE_FWD_EN.
// Latency: an entry accepted at edge N is presented on rf_* in cycle N+1; pend/fwd combinational from queue state.
// Backpressure: readies from start-of-cycle count only; load owns the last free slot; no stall from the register file.
module wb_write_queue #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            alu_valid,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_data,
   output logic            alu_ready,
   input  logic            ld_valid,
   input  logic [4:0]      ld_rd,
   input  logic [XLEN-1:0] ld_data,
   output logic            ld_ready,
   output logic            rf_we,
   output logic [4:0]      rf_a3,
   output logic [XLEN-1:0] rf_wd,
   input  logic [4:0]      q_a1,
   input  logic [4:0]      q_a2,
   output logic            pend1,
   output logic            pend2,
   output logic [XLEN-1:0] fwd1_data,
   output logic [XLEN-1:0] fwd2_data
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]   r_rd_ptr;
   logic [AW-1:0]   r_wr_ptr;
   logic [CW-1:0]   r_count;
   logic [4:0]      r_rd_mem   [DEPTH];
   logic [XLEN-1:0] r_data_mem [DEPTH];

   logic            w_ld_enq;
   logic            w_alu_enq;
   logic            w_pop;
   logic [AW-1:0]   w_alu_slot;
   logic [DEPTH-1:0] w_vld;
   logic            w_hit1;
   logic            w_hit2;

   assign ld_ready  = (r_count < CW'(DEPTH));
   assign alu_ready = (r_count < CW'(DEPTH - 1)) | (ld_ready & ~ld_valid);

   // x0 handshakes complete but never occupy a slot
   assign w_ld_enq   = ld_valid & ld_ready & (ld_rd != 5'd0);
   assign w_alu_enq  = alu_valid & alu_ready & (alu_rd != 5'd0);
   assign w_pop      = (r_count != '0);
   assign w_alu_slot = r_wr_ptr + AW'(w_ld_enq);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_rd_ptr <= r_rd_ptr + AW'(w_pop);
         r_wr_ptr <= r_wr_ptr + AW'(w_ld_enq) + AW'(w_alu_enq);
         r_count  <= r_count + CW'(w_ld_enq) + CW'(w_alu_enq) - CW'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_ld_enq) begin
         r_rd_mem[r_wr_ptr]   <= ld_rd;
         r_data_mem[r_wr_ptr] <= ld_data;
      end
      if (w_alu_enq) begin
         r_rd_mem[w_alu_slot]   <= alu_rd;
         r_data_mem[w_alu_slot] <= alu_data;
      end
   end

   assign rf_we = w_pop;
   assign rf_a3 = w_pop ? r_rd_mem[r_rd_ptr]   : 5'd0;
   assign rf_wd = w_pop ? r_data_mem[r_rd_ptr] : '0;

   // A slot is live when its distance from the head is below the occupancy
   always_comb begin
      w_vld = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_vld[i] = ({1'b0, AW'(i) - r_rd_ptr} < r_count);
      end
   end

   always_comb begin
      w_hit1 = 1'b0;
      w_hit2 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         w_hit1 = w_hit1 | (w_vld[i] & (r_rd_mem[i] == q_a1));
         w_hit2 = w_hit2 | (w_vld[i] & (r_rd_mem[i] == q_a2));
      end
   end

   assign pend1 = w_hit1 & (q_a1 != 5'd0);
   assign pend2 = w_hit2 & (q_a2 != 5'd0);

`ifdef WB_QUEUE_FWD_EN
   logic [AW-1:0]   w_slot;
   logic [XLEN-1:0] w_fwd1;
   logic [XLEN-1:0] w_fwd2;

   // Walk oldest to youngest so the last match wins
   always_comb begin
      w_slot = '0;
      w_fwd1 = '0;
      w_fwd2 = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_slot = r_rd_ptr + AW'(k);
         if (w_vld[w_slot] && (r_rd_mem[w_slot] == q_a1)) w_fwd1 = r_data_mem[w_slot];
         if (w_vld[w_slot] && (r_rd_mem[w_slot] == q_a2)) w_fwd2 = r_data_mem[w_slot];
      end
   end

   assign fwd1_data = pend1 ? w_fwd1 : '0;
   assign fwd2_data = pend2 ? w_fwd2 : '0;
`else
   assign fwd1_data = '0;
   assign fwd2_data = '0;
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Random and directed stimulus against a queue-based reference model of the writeback queue.
module tb_wb_write_queue;

   localparam int DEPTH = 4;
   localparam int XLEN  = 32;

   typedef struct {
      logic [4:0]      rd;
      logic [XLEN-1:0] d;
   } ent_t;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            alu_valid = 1'b0;
   logic [4:0]      alu_rd = '0;
   logic [XLEN-1:0] alu_data = '0;
   logic            alu_ready;
   logic            ld_valid = 1'b0;
   logic [4:0]      ld_rd = '0;
   logic [XLEN-1:0] ld_data = '0;
   logic            ld_ready;
   logic            rf_we;
   logic [4:0]      rf_a3;
   logic [XLEN-1:0] rf_wd;
   logic [4:0]      q_a1 = '0;
   logic [4:0]      q_a2 = '0;
   logic            pend1;
   logic            pend2;
   logic [XLEN-1:0] fwd1_data;
   logic [XLEN-1:0] fwd2_data;

   int   n_checks = 0;
   int   n_errors = 0;
   ent_t mq[$];

   always #5 clk = ~clk;

   wb_write_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
      .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd),
      .q_a1(q_a1), .q_a2(q_a2), .pend1(pend1), .pend2(pend2),
      .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
   );

   task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic model_pend(input logic [4:0] a);
      if (a == 5'd0) return 1'b0;
      foreach (mq[i]) if (mq[i].rd == a) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [XLEN-1:0] model_fwd(input logic [4:0] a);
`ifdef WB_QUEUE_FWD_EN
      if (a == 5'd0) return '0;
      for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].rd == a) return mq[i].d;
`endif
      return '0;
   endfunction

   // One clock cycle: drive at negedge, compare everything, then advance the model to the next edge
   task automatic cycle(input logic lv, input logic [4:0] lrd, input logic [XLEN-1:0] ldat,
                        input logic av, input logic [4:0] ard, input logic [XLEN-1:0] adat,
                        input logic [4:0] a1, input logic [4:0] a2);
      int  used;
      int  free_after_ld;
      bit  exp_lr, exp_ar;
      @(negedge clk);
      ld_valid = lv;  ld_rd = lrd;  ld_data = ldat;
      alu_valid = av; alu_rd = ard; alu_data = adat;
      q_a1 = a1; q_a2 = a2;
      #1;
      used          = mq.size();
      exp_lr        = (used < DEPTH);
      free_after_ld = DEPTH - used - ((lv && exp_lr) ? 1 : 0);
      exp_ar        = (free_after_ld > 0);
      chk("ld_ready",  XLEN'(ld_ready),  XLEN'(exp_lr));
      chk("alu_ready", XLEN'(alu_ready), XLEN'(exp_ar));
      chk("rf_we",     XLEN'(rf_we),     XLEN'(used > 0));
      chk("rf_a3",     XLEN'(rf_a3),     (used > 0) ? XLEN'(mq[0].rd) : '0);
      chk("rf_wd",     rf_wd,            (used > 0) ? mq[0].d : '0);
      chk("pend1",     XLEN'(pend1),     XLEN'(model_pend(a1)));
      chk("pend2",     XLEN'(pend2),     XLEN'(model_pend(a2)));
      chk("fwd1",      fwd1_data,        model_fwd(a1));
      chk("fwd2",      fwd2_data,        model_fwd(a2));
      if (used > 0) mq.delete(0);
      if (lv && exp_lr && lrd != 5'd0) mq.push_back('{lrd, ldat});
      if (av && exp_ar && ard != 5'd0) mq.push_back('{ard, adat});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      q_a1 = 5'd3;
      #12;
      chk("rst_rf_we",     XLEN'(rf_we),     '0);
      chk("rst_rf_a3",     XLEN'(rf_a3),     '0);
      chk("rst_rf_wd",     rf_wd,            '0);
      chk("rst_pend1",     XLEN'(pend1),     '0);
      chk("rst_fwd1",      fwd1_data,        '0);
      chk("rst_ld_ready",  XLEN'(ld_ready),  XLEN'(1));
      chk("rst_alu_ready", XLEN'(alu_ready), XLEN'(1));
      @(negedge clk);
      rst = 1'b1;
      idle(1);

      // Single ALU write: visible one cycle after acceptance, gone the cycle after
      cycle(0, 0, 0, 1, 5'd5, 32'h1234, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 5'd5, 0);
      chk("single_a3", XLEN'(rf_a3), 32'd5);
      chk("single_wd", rf_wd, 32'h1234);
      cycle(0, 0, 0, 0, 0, 0, 5'd5, 0);
      chk("single_done_we", XLEN'(rf_we), '0);

      // Dual accept to the same register: load older, ALU younger
      cycle(1, 5'd7, 32'hAAAA, 1, 5'd7, 32'hBBBB, 5'd7, 0);
      cycle(0, 0, 0, 0, 0, 0, 5'd7, 5'd4);
      chk("dual_first_wd", rf_wd, 32'hAAAA);
      cycle(0, 0, 0, 0, 0, 0, 5'd7, 5'd0);
      chk("dual_second_wd", rf_wd, 32'hBBBB);
      idle(2);

      // x0 discard
      cycle(0, 0, 0, 1, 5'd0, 32'hDEAD, 0, 0);
      chk("x0_alu_ready", XLEN'(alu_ready), XLEN'(1));
      idle(2);

      // Build up occupancy and exercise load priority for the last slot
      cycle(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 0);
      cycle(1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 5'd3, 5'd4);
      cycle(1, 5'd6, 32'h66, 1, 5'd8, 32'h88, 5'd3, 5'd4);
      chk("prio_alu_ready", XLEN'(alu_ready), '0);
      cycle(0, 0, 0, 1, 5'd9, 32'h99, 5'd3, 5'd9);
      idle(1);

      // Asynchronous reset with entries in flight
      cycle(1, 5'd3, 32'h101, 1, 5'd3, 32'h102, 5'd3, 0);
      cycle(1, 5'd4, 32'h103, 1, 5'd5, 32'h104, 5'd3, 0);
      @(negedge clk);
      ld_valid = 1'b0; alu_valid = 1'b0; q_a1 = 5'd3;
      #2;
      chk("prerst_rf_we", XLEN'(rf_we), XLEN'(mq.size() > 0));
      chk("prerst_pend1", XLEN'(pend1), XLEN'(model_pend(5'd3)));
      rst = 1'b0;
      #1;
      chk("midrst_rf_we", XLEN'(rf_we), '0);
      chk("midrst_pend1", XLEN'(pend1), '0);
      chk("midrst_fwd1",  fwd1_data,    '0);
      mq.delete();
      @(negedge clk);
      rst = 1'b1;
      idle(4);

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         cycle(($urandom_range(0, 99) < 55), 5'($urandom_range(0, 7)), $urandom,
               ($urandom_range(0, 99) < 70), 5'($urandom_range(0, 7)), $urandom,
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
      idle(DEPTH + 2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
